mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  MEM stage directly downstream of execute. Consumes the EX/MEM (*_pype2) bundle.
//  Runs load/store on a req/ack data-memory bus and aligns store byte lanes.
//  Sign/zero-extends load data and registers the MEM/WB (*_pype3) bundle.
//  Drives mem_stall (upstream keep) while a bus transaction is outstanding.
// PARAMETERS
//  ACK_TIMEOUT  255  max WAIT cycles before abort with bus_err; 0 = never time out
//  CNT_W        8    width of timeout counter (must hold ACK_TIMEOUT)
// PORTS
//  clk                      in   1   clock; all state on posedge
//  rst                      in   1   synchronous, active-high reset
//  nop                      in   1   flush: write bubble into pype3
//  ALU_co_pype2             in   32  effective address / ALU result
//  read_data2_pype2         in   32  store data, low-aligned, pre-truncated
//  WReg_pype2               in   5   destination register
//  writeback_control_pype2  in   3   WB control, passed through
//  MemRW_pype2              in   2   [1]=load, [0]=store; 00 = no memory op
//  dsize_pype2              in   2   00 byte, 01 half, 10 word
//  funct3_pype2             in   3   bit2=1 -> unsigned load
//  PCp4_pype2               in   32  PC+4, passed through
//  dmem_req                 out  1   request valid
//  dmem_we                  out  1   1=write
//  dmem_addr                out  32  {ALU_co_pype2[31:2],2'b00}
//  dmem_wstrb               out  4   byte enables
//  dmem_wdata               out  32  lane-replicated store data
//  dmem_ack                 in   1   transaction complete (rdata valid this cycle)
//  dmem_rdata               in   32  raw word read data
//  mem_stall                out  1   hold upstream stages (keep)
//  mem_fwd_data             out  32  comb. result of completing op, for ID/EX forwarding
//  misalign_exc             out  1   1-cycle pulse: misaligned access
//  bus_err                  out  1   1-cycle pulse: ack timeout
//  fault_addr               out  32  address of last misalign/bus_err
//  ALU_co_pype3, load_data_pype3, PCp4_pype3  out 32  MEM/WB data
//  WReg_pype3               out  5
//  writeback_control_pype3  out  3
// BEHAVIOUR
//  - Reset: every output and pype3 register = 0, FSM=IDLE, counter=0.
//  - Reset beats everything and aborts a WAIT: dmem_req low from the next cycle.
//  - memop = |MemRW_pype2 & !nop.
//  - misal = (half & a[0]) | (word & |a[1:0]); a = ALU_co_pype2.
//  - FSM IDLE (memop & !misal):
//    - dmem_req=1 combinationally in the same cycle.
//    - ack same cycle -> zero-wait completion, stay IDLE.
//    - else -> WAIT, mem_stall=1.
//  - FSM WAIT:
//    - req, we, addr, wstrb and wdata held stable; upstream holds pype2 via mem_stall.
//    - nop is ignored while in WAIT.
//    - ack -> complete, go IDLE.
//    - counter==ACK_TIMEOUT-1 without ack -> abort, bus_err pulse, IDLE.
//  - mem_stall = memop & !misal & !dmem_ack & !abort. Never high for non-memory ops.
//  - pype3 update, on any cycle with mem_stall=0:
//    - nop -> all pype3 = 0.
//    - misal or abort -> bubble (writeback_control_pype3=0, WReg_pype3=0),
//      fault_addr=a, matching exc pulse.
//    - else -> capture pass-through fields; load_data_pype3 = extended load, else 0.
//  - Store lanes:
//    - byte: wstrb=4'b0001<<a[1:0], wdata={4{d[7:0]}}.
//    - half: wstrb=4'b0011<<{a[1],1'b0}, wdata={2{d[15:0]}}.
//    - word: wstrb=4'hF, wdata=d.
//    - load: we=0, wstrb=4'h0.
//  - Load extract: lane = dmem_rdata >> (8*a[1:0]).
//    - byte/half sign-extended unless funct3_pype2[2]; word unmodified.
//  - mem_fwd_data = load ? extended data : ALU_co_pype2.
//  - Back-to-back memory ops: next request may issue in the cycle after completion.
// TESTING
//  1 lw a=0x100, ack same cycle, rdata=0xDEADBEEF
//    -> mem_stall never 1; next cycle load_data_pype3=0xDEADBEEF.
//  2 lb a=0x103, rdata=0x80FF_FFFF, ack after 3 cycles
//    -> mem_stall=1 for 3 cycles; load_data_pype3=0xFFFFFF80.
//    -> same with funct3=3'b100 gives 0x00000080.
//  3 sh a=0x102, d=0x0000ABCD -> dmem_wstrb=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1.
//  4 lw a=0x101 -> no dmem_req, misalign_exc pulse, fault_addr=0x101, WReg_pype3=0.
//  5 ACK_TIMEOUT=4, no ack -> req held 4 cycles then dropped, bus_err pulse, bubble.
//  6 rst high during WAIT -> next cycle dmem_req=0, mem_stall=0, all pype3=0.
//    -> nop in WAIT does not drop req.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: drives the req/ack data-memory bus for loads and stores,
// aligns store lanes, extends load data and registers the MEM/WB bundle.
module mem_access #(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nop,
   input  logic [31:0] ALU_co_pype2,
   input  logic [31:0] read_data2_pype2,
   input  logic [4:0]  WReg_pype2,
   input  logic [2:0]  writeback_control_pype2,
   input  logic [1:0]  MemRW_pype2,
   input  logic [1:0]  dsize_pype2,
   input  logic [2:0]  funct3_pype2,
   input  logic [31:0] PCp4_pype2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic [31:0] mem_fwd_data,
   output logic        misalign_exc,
   output logic        bus_err,
   output logic [31:0] fault_addr,
   output logic [31:0] ALU_co_pype3,
   output logic [31:0] load_data_pype3,
   output logic [31:0] PCp4_pype3,
   output logic [4:0]  WReg_pype3,
   output logic [2:0]  writeback_control_pype3
);
   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [31:0] a;
   logic        in_wait, memop, is_load, is_store, is_half, is_word;
   logic        misal, go, abort;
   logic [31:0] shifted, load_ext;
   logic        sgn;
   logic        unused_funct3;

   assign a             = ALU_co_pype2;
   assign in_wait       = (state_reg == WAIT);
   // nop may not cancel a transaction that is already on the bus
   assign memop         = (|MemRW_pype2) & (!nop | in_wait);
   assign is_load       = MemRW_pype2[1];
   assign is_store      = MemRW_pype2[0] & !MemRW_pype2[1];
   assign is_half       = (dsize_pype2 == 2'b01);
   assign is_word       = dsize_pype2[1];
   assign misal         = memop & ((is_half & a[0]) | (is_word & (|a[1:0])));
   assign go            = memop & !misal & !rst;
   assign abort         = in_wait & !dmem_ack & (ACK_TIMEOUT != 0) & (cnt_reg >= LAST_CNT);
   assign unused_funct3 = ^funct3_pype2[1:0];

   assign dmem_req  = go;
   assign dmem_we   = go & is_store;
   assign dmem_addr = {a[31:2], 2'b00};
   assign mem_stall = go & !dmem_ack & !abort;

   always_comb begin
      dmem_wstrb = 4'h0;
      dmem_wdata = read_data2_pype2;
      case (dsize_pype2)
         2'b00: begin
            dmem_wstrb = 4'b0001 << a[1:0];
            dmem_wdata = {4{read_data2_pype2[7:0]}};
         end
         2'b01: begin
            dmem_wstrb = 4'b0011 << {a[1], 1'b0};
            dmem_wdata = {2{read_data2_pype2[15:0]}};
         end
         default: begin
            dmem_wstrb = 4'hF;
            dmem_wdata = read_data2_pype2;
         end
      endcase
      if (!(go & is_store))
         dmem_wstrb = 4'h0;
   end

   assign shifted = dmem_rdata >> {a[1:0], 3'b000};
   assign sgn     = !funct3_pype2[2];

   always_comb begin
      case (dsize_pype2)
         2'b00:   load_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
         default: load_ext = dmem_rdata;
      endcase
   end

   assign mem_fwd_data = is_load ? load_ext : a;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg               <= IDLE;
         cnt_reg                 <= '0;
         misalign_exc            <= 1'b0;
         bus_err                 <= 1'b0;
         fault_addr              <= '0;
         ALU_co_pype3            <= '0;
         load_data_pype3         <= '0;
         PCp4_pype3              <= '0;
         WReg_pype3              <= '0;
         writeback_control_pype3 <= '0;
      end else begin
         misalign_exc <= 1'b0;
         bus_err      <= 1'b0;
         case (state_reg)
            IDLE: begin
               // the issuing cycle counts as the first cycle of the request
               if (go & !dmem_ack) begin
                  state_reg <= WAIT;
                  cnt_reg   <= CNT_W'(1);
               end
            end
            default: begin
               if (dmem_ack | abort) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         endcase

         if (!mem_stall) begin
            if (nop & !in_wait) begin
               ALU_co_pype3            <= '0;
               load_data_pype3         <= '0;
               PCp4_pype3              <= '0;
               WReg_pype3              <= '0;
               writeback_control_pype3 <= '0;
            end else if (misal | abort) begin
               ALU_co_pype3            <= a;
               load_data_pype3         <= '0;
               PCp4_pype3              <= PCp4_pype2;
               WReg_pype3              <= '0;
               writeback_control_pype3 <= '0;
               fault_addr              <= a;
               misalign_exc            <= misal;
               bus_err                 <= abort;
            end else begin
               ALU_co_pype3            <= a;
               load_data_pype3         <= (memop & is_load) ? load_ext : 32'h0;
               PCp4_pype3              <= PCp4_pype2;
               WReg_pype3              <= WReg_pype2;
               writeback_control_pype3 <= writeback_control_pype2;
            end
         end
      end
   end
endmodule
